// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// One operation is in flight at a time: a request is accepted in IDLE,
// its result is registered and held in RESP until the owning requester
// takes it, then the block returns to IDLE and bumps op_count.
//
// Handshake rules (all channels): a transfer happens on a rising edge
// where valid and ready are both 1. req<i>_ready depends only on the
// req valids, the current state and last_grant. Once rsp<i>_valid rises,
// it stays high, and rsp data/carry/zero stay stable, until the edge
// where rsp<i>_ready is also 1.
module alu_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_opcode,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp0_carry,
  output logic        rsp0_zero,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_opcode,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        rsp1_carry,
  output logic        rsp1_zero,
  output logic [15:0] op_count,
  output logic        state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [31:0] data_q, data_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic [15:0] op_count_q, op_count_d;

  logic        grant0, grant1;
  logic        accept, rsp_hs;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [32:0] a33, b33, res33;

  // Grant: a lone valid wins; on a tie requester 0 wins under fixed
  // priority, otherwise whoever was not served last.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | FIXED_PRIORITY | last_grant_q);
    grant1     = req1_valid & ~grant0;
    req0_ready = (state_q == IDLE) & grant0;
    req1_ready = (state_q == IDLE) & grant1;
    accept     = req0_ready | req1_ready;
    rsp_hs     = (state_q == RESP) & (owner_q ? rsp1_ready : rsp0_ready);
  end

  // Shared ALU on 33-bit zero-extended operands of the granted requester.
  always_comb begin
    alu_op = grant1 ? req1_opcode : req0_opcode;
    alu_a  = grant1 ? req1_a : req0_a;
    alu_b  = grant1 ? req1_b : req0_b;
    a33    = {1'b0, alu_a};
    b33    = {1'b0, alu_b};
    res33  = 33'd0;
    case (alu_op)
      4'd1: res33 = a33 + b33;
      4'd2: res33 = a33 - b33;
      4'd3: res33 = (alu_b > 32'd32) ? 33'd0 : (a33 << alu_b[5:0]);
      // Arithmetic right shift of a zero-extended value is a logical shift.
      4'd4,
      4'd5: res33 = (alu_b > 32'd32) ? 33'd0 : (a33 >> alu_b[5:0]);
      4'd6: res33 = a33 & b33;
      4'd7: res33 = a33 | b33;
      4'd8: res33 = a33 ^ b33;
      4'd9: res33 = ~a33;
      default: res33 = 33'd0;
    endcase
  end

  // Next-state: capture the result on accept, release it on the response handshake.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    data_d       = data_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = RESP;
          owner_d      = grant1;
          last_grant_d = grant1;
          data_d       = res33[31:0];
          carry_d      = res33[32];
          zero_d       = (res33[31:0] == 32'd0);
        end
      end
      RESP: begin
        if (rsp_hs) begin
          state_d    = IDLE;
          op_count_d = op_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and result registers; reset drops any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      data_q       <= 32'd0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      op_count_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      data_q       <= data_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
      op_count_q   <= op_count_d;
    end
  end

  // Response outputs come straight from registers.
  always_comb begin
    rsp0_valid = (state_q == RESP) & ~owner_q;
    rsp1_valid = (state_q == RESP) & owner_q;
    rsp0_data  = data_q;
    rsp0_carry = carry_q;
    rsp0_zero  = zero_q;
    rsp1_data  = data_q;
    rsp1_carry = carry_q;
    rsp1_zero  = zero_q;
    op_count   = op_count_q;
    state_dbg  = (state_q == RESP);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance (dut) and a
// fixed-priority instance (dut_fp) sharing clock and reset.
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_carry, rsp0_zero, rsp1_carry, rsp1_zero;
  logic [15:0] op_count;
  logic        state_dbg;

  logic        f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
  logic [3:0]  f_req0_opcode, f_req1_opcode;
  logic [31:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
  logic        f_rsp0_valid, f_rsp0_ready, f_rsp1_valid, f_rsp1_ready;
  logic [31:0] f_rsp0_data, f_rsp1_data;
  logic        f_rsp0_carry, f_rsp0_zero, f_rsp1_carry, f_rsp1_zero;
  logic [15:0] f_op_count;
  logic        f_state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Edge-opcode table: opcode, a, b, expected data, carry, zero.
  logic [3:0]  t_op  [10] = '{4'd3, 4'hF, 4'd3, 4'd3, 4'd4, 4'd5, 4'd9, 4'd6, 4'd4, 4'd2};
  logic [31:0] t_a   [10] = '{32'h80000001, 32'h00001234, 32'h00000001, 32'h00000001, 32'h80000000,
                              32'h80000000, 32'h00000000, 32'h0000F0F0, 32'h00000001, 32'h00000007};
  logic [31:0] t_b   [10] = '{32'd1, 32'h00005678, 32'd33, 32'd32, 32'd31,
                              32'd4, 32'd0, 32'h00000FF0, 32'hFFFFFFFF, 32'd5};
  logic [31:0] t_d   [10] = '{32'h00000002, 32'h0, 32'h0, 32'h0, 32'h00000001,
                              32'h08000000, 32'hFFFFFFFF, 32'h000000F0, 32'h0, 32'h00000002};
  logic        t_c   [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        t_z   [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  alu_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_carry(rsp0_carry), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_carry(rsp1_carry), .rsp1_zero(rsp1_zero),
    .op_count(op_count), .state_dbg(state_dbg)
  );

  alu_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_opcode(f_req0_opcode),
    .req0_a(f_req0_a), .req0_b(f_req0_b),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(f_rsp0_ready), .rsp0_data(f_rsp0_data),
    .rsp0_carry(f_rsp0_carry), .rsp0_zero(f_rsp0_zero),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_opcode(f_req1_opcode),
    .req1_a(f_req1_a), .req1_b(f_req1_b),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(f_rsp1_ready), .rsp1_data(f_rsp1_data),
    .rsp1_carry(f_rsp1_carry), .rsp1_zero(f_rsp1_zero),
    .op_count(f_op_count), .state_dbg(f_state_dbg)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d passed)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_opcode = 4'd0; req0_a = 32'd0; req0_b = 32'd0; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_opcode = 4'd0; req1_a = 32'd0; req1_b = 32'd0; rsp1_ready = 1'b0;
    f_req0_valid = 1'b0; f_req0_opcode = 4'd0; f_req0_a = 32'd0; f_req0_b = 32'd0; f_rsp0_ready = 1'b0;
    f_req1_valid = 1'b0; f_req1_opcode = 4'd0; f_req1_a = 32'd0; f_req1_b = 32'd0; f_rsp1_ready = 1'b0;
  endtask

  // Pulse reset for one cycle and release it on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_checks++; if (rsp0_valid !== 1'b0) $display("FAIL reset_rsp0_valid got %b exp 0", rsp0_valid); else n_pass++;
    n_checks++; if (rsp1_valid !== 1'b0) $display("FAIL reset_rsp1_valid got %b exp 0", rsp1_valid); else n_pass++;
    n_checks++; if (rsp0_data !== 32'd0) $display("FAIL reset_data got %h exp 0", rsp0_data); else n_pass++;
    n_checks++; if (rsp0_carry !== 1'b0) $display("FAIL reset_carry got %b exp 0", rsp0_carry); else n_pass++;
    n_checks++; if (rsp0_zero !== 1'b0) $display("FAIL reset_zero got %b exp 0", rsp0_zero); else n_pass++;
    n_checks++; if (op_count !== 16'd0) $display("FAIL reset_op_count got %h exp 0", op_count); else n_pass++;
    n_checks++; if (state_dbg !== 1'b0) $display("FAIL reset_state got %b exp 0", state_dbg); else n_pass++;
    n_checks++; if (req0_ready !== 1'b1) $display("FAIL reset_first_grant_r0 got %b exp 1", req0_ready); else n_pass++;
    n_checks++; if (req1_ready !== 1'b0) $display("FAIL reset_first_grant_r1 got %b exp 0", req1_ready); else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // Add with carry out; accept lands on the first edge after reset release.
  task automatic test_add();
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_opcode = 4'd1; req0_a = 32'hFFFFFFFF; req0_b = 32'd1;
    #1;
    n_checks++; if (req0_ready !== 1'b1) $display("FAIL add_req0_ready got %b exp 1", req0_ready); else n_pass++;
    n_checks++; if (req1_ready !== 1'b0) $display("FAIL add_req1_ready got %b exp 0", req1_ready); else n_pass++;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    n_checks++; if (rsp0_valid !== 1'b1) $display("FAIL add_rsp0_valid got %b exp 1", rsp0_valid); else n_pass++;
    n_checks++; if (rsp1_valid !== 1'b0) $display("FAIL add_rsp1_valid got %b exp 0", rsp1_valid); else n_pass++;
    n_checks++; if (rsp0_data !== 32'd0) $display("FAIL add_data got %h exp 0", rsp0_data); else n_pass++;
    n_checks++; if (rsp0_carry !== 1'b1) $display("FAIL add_carry got %b exp 1", rsp0_carry); else n_pass++;
    n_checks++; if (rsp0_zero !== 1'b1) $display("FAIL add_zero got %b exp 1", rsp0_zero); else n_pass++;
    rsp0_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (rsp0_valid !== 1'b0) $display("FAIL add_rsp0_done got %b exp 0", rsp0_valid); else n_pass++;
    n_checks++; if (op_count !== 16'd1) $display("FAIL add_op_count got %h exp 1", op_count); else n_pass++;
    rsp0_ready = 1'b0;
  endtask

  // Both requesters held valid: grants alternate 0,1,0,1.
  task automatic test_round_robin();
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_opcode = 4'd2; req0_a = 32'd5; req0_b = 32'd7;
    req1_valid = 1'b1; req1_opcode = 4'd8; req1_a = 32'h0000F0F0; req1_b = 32'h00000FF0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (req0_ready !== (k % 2 == 0)) $display("FAIL rr_grant0 op %0d got %b exp %b", k, req0_ready, (k % 2 == 0)); else n_pass++;
      n_checks++; if (req1_ready !== (k % 2 == 1)) $display("FAIL rr_grant1 op %0d got %b exp %b", k, req1_ready, (k % 2 == 1)); else n_pass++;
      @(negedge clk);
      #1;
      if (k % 2 == 0) begin
        n_checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) $display("FAIL rr_owner0 op %0d got v0=%b v1=%b exp 1 0", k, rsp0_valid, rsp1_valid); else n_pass++;
        n_checks++; if (rsp0_data !== 32'hFFFFFFFE || rsp0_carry !== 1'b1) $display("FAIL rr_sub op %0d got %h c%b exp fffffffe c1", k, rsp0_data, rsp0_carry); else n_pass++;
      end else begin
        n_checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) $display("FAIL rr_owner1 op %0d got v0=%b v1=%b exp 0 1", k, rsp0_valid, rsp1_valid); else n_pass++;
        n_checks++; if (rsp1_data !== 32'h0000FF00 || rsp1_carry !== 1'b0) $display("FAIL rr_xor op %0d got %h c%b exp 0000ff00 c0", k, rsp1_data, rsp1_carry); else n_pass++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    n_checks++; if (op_count !== 16'd4) $display("FAIL rr_op_count got %h exp 4", op_count); else n_pass++;
  endtask

  // Fixed priority: requester 1 never gets in while requester 0 stays valid.
  task automatic test_fixed_priority();
    @(negedge clk);
    f_req0_valid = 1'b1; f_req0_opcode = 4'd1; f_req0_a = 32'd3; f_req0_b = 32'd4;
    f_req1_valid = 1'b1; f_req1_opcode = 4'd2; f_req1_a = 32'd9; f_req1_b = 32'd1;
    f_rsp0_ready = 1'b1; f_rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (f_req0_ready !== 1'b1 || f_req1_ready !== 1'b0) $display("FAIL fp_grant op %0d got r0=%b r1=%b exp 1 0", k, f_req0_ready, f_req1_ready); else n_pass++;
      @(negedge clk);
      #1;
      n_checks++; if (f_rsp0_valid !== 1'b1 || f_rsp1_valid !== 1'b0) $display("FAIL fp_owner op %0d got v0=%b v1=%b exp 1 0", k, f_rsp0_valid, f_rsp1_valid); else n_pass++;
      n_checks++; if (f_rsp0_data !== 32'd7) $display("FAIL fp_data op %0d got %h exp 7", k, f_rsp0_data); else n_pass++;
      n_checks++; if (f_req1_ready !== 1'b0) $display("FAIL fp_resp_ready1 op %0d got %b exp 0", k, f_req1_ready); else n_pass++;
      @(negedge clk);
    end
    f_req0_valid = 1'b0; f_req1_valid = 1'b0; f_rsp0_ready = 1'b0; f_rsp1_ready = 1'b0;
    #1;
    n_checks++; if (f_op_count !== 16'd4) $display("FAIL fp_op_count got %h exp 4", f_op_count); else n_pass++;
  endtask

  // rsp1_ready held low for 5 cycles with noise on the other inputs.
  task automatic test_backpressure();
    @(negedge clk);
    req1_valid = 1'b1; req1_opcode = 4'd7; req1_a = 32'h00000F00; req1_b = 32'h000000F0;
    #1;
    n_checks++; if (req1_ready !== 1'b1) $display("FAIL bp_accept got %b exp 1", req1_ready); else n_pass++;
    @(negedge clk);
    req0_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (rsp1_valid !== 1'b1) $display("FAIL bp_rsp1_valid cyc %0d got %b exp 1", k, rsp1_valid); else n_pass++;
      n_checks++; if (rsp1_data !== 32'h00000FF0 || rsp1_carry !== 1'b0 || rsp1_zero !== 1'b0) $display("FAIL bp_data cyc %0d got %h c%b z%b exp 00000ff0 c0 z0", k, rsp1_data, rsp1_carry, rsp1_zero); else n_pass++;
      n_checks++; if (rsp0_valid !== 1'b0) $display("FAIL bp_rsp0_valid cyc %0d got %b exp 0", k, rsp0_valid); else n_pass++;
      n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL bp_req_ready cyc %0d got %b %b exp 0 0", k, req0_ready, req1_ready); else n_pass++;
      n_checks++; if (op_count !== 16'd4) $display("FAIL bp_op_count cyc %0d got %h exp 4", k, op_count); else n_pass++;
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    #1;
    n_checks++; if (rsp1_valid !== 1'b1) $display("FAIL bp_hs_cycle_valid got %b exp 1", rsp1_valid); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (rsp1_valid !== 1'b0) $display("FAIL bp_after_valid got %b exp 0", rsp1_valid); else n_pass++;
    n_checks++; if (state_dbg !== 1'b0) $display("FAIL bp_after_state got %b exp 0", state_dbg); else n_pass++;
    n_checks++; if (op_count !== 16'd5) $display("FAIL bp_after_op_count got %h exp 5", op_count); else n_pass++;
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL bp_after_grant got %b %b exp 1 0", req0_ready, req1_ready); else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  // Shift edges, bitwise ops, undefined opcode, then reset during RESP.
  task automatic test_edge_ops();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_opcode = t_op[i]; req0_a = t_a[i]; req0_b = t_b[i]; rsp0_ready = 1'b0;
      #1;
      n_checks++; if (req0_ready !== 1'b1) $display("FAIL edge_accept %0d got %b exp 1", i, req0_ready); else n_pass++;
      @(negedge clk);
      req0_valid = 1'b0; rsp0_ready = 1'b1;
      #1;
      n_checks++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== t_d[i] || rsp0_carry !== t_c[i] || rsp0_zero !== t_z[i])
        $display("FAIL edge_op %0d got v%b %h c%b z%b exp v1 %h c%b z%b", i, rsp0_valid, rsp0_data, rsp0_carry, rsp0_zero, t_d[i], t_c[i], t_z[i]);
      else n_pass++;
    end
    @(negedge clk);
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_opcode = 4'd1; req0_a = 32'd1; req0_b = 32'd2;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    n_checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd3) $display("FAIL rst_pre_rsp got v%b %h exp v1 3", rsp0_valid, rsp0_data); else n_pass++;
    n_checks++; if (op_count !== 16'd15) $display("FAIL rst_pre_op_count got %h exp f", op_count); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp0_valid !== 1'b0) $display("FAIL rst_mid_rsp0_valid got %b exp 0", rsp0_valid); else n_pass++;
    n_checks++; if (op_count !== 16'd0) $display("FAIL rst_mid_op_count got %h exp 0", op_count); else n_pass++;
    n_checks++; if (rsp0_data !== 32'd0 || state_dbg !== 1'b0) $display("FAIL rst_mid_state got %h s%b exp 0 s0", rsp0_data, state_dbg); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // 65535 back-to-back operations, then one more to wrap op_count.
  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_opcode = 4'd0; rsp0_ready = 1'b1;
    repeat (2 * 65535) @(negedge clk);
    #1;
    n_checks++; if (op_count !== 16'hFFFF) $display("FAIL wrap_preset got %h exp ffff", op_count); else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (op_count !== 16'h0000) $display("FAIL wrap_rollover got %h exp 0000", op_count); else n_pass++;
    req0_valid = 1'b0; rsp0_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_add();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_edge_ops();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIORITY, default 0, meaning 0 = round-robin arbitration and 1 = requester 0 always wins.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed first as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
REQ-003 The block SHALL have the following ports for each requester i in {0,1}:
- req<i>_valid  in  1  operation request
- req<i>_ready  out  1  request accepted this cycle when also valid
- req<i>_opcode  in  4  ALU opcode
- req<i>_a  in  32  operand 1
- req<i>_b  in  32  operand 2
- rsp<i>_valid  out  1  result available to requester i
- rsp<i>_ready  in  1  requester i consumes the result
- rsp<i>_data  out  32  result
- rsp<i>_carry  out  1  carry or borrow flag
- rsp<i>_zero  out  1  result == 0
REQ-004 The block SHALL have output port op_count, 16 bits, counting completed operations.

Function
REQ-005 The block SHALL share one combinational ALU between two requesters and keep at most one operation in flight.
REQ-006 The block SHALL have exactly two states, IDLE and RESP; the reset state SHALL be IDLE.
REQ-007 In IDLE, req<i>_ready SHALL be 1 only for the granted requester and SHALL be 0 for the other; in RESP both readies SHALL be 0.
REQ-008 Grant in IDLE SHALL be decided as follows:
- only one requester valid -> that requester;
- both valid with FIXED_PRIORITY=1 -> requester 0;
- both valid with FIXED_PRIORITY=0 -> the requester not granted last (last_grant resets to 1, so requester 0 wins first).
REQ-009 req<i>_ready SHALL be combinational from the valids and last_grant only, with no dependence on opcode or operands.
REQ-010 On an accept (valid & ready in IDLE), the block SHALL compute the ALU on that requester's opcode/a/b in the same cycle, register data, carry and zero plus the owner id, update last_grant, and go to RESP.
REQ-011 rsp<owner>_valid SHALL be 1 from the cycle after accept until the cycle in which rsp<owner>_ready is 1, inclusive.
REQ-012 The non-owner rsp_valid SHALL be 0 throughout.
REQ-013 rsp data, carry and zero SHALL be stable while rsp_valid is high.
REQ-014 On a response handshake (RESP & rsp<owner>_ready), the block SHALL return to IDLE and increment op_count by 1, wrapping 0xFFFF -> 0x0000.
REQ-015 A new request SHALL NOT be accepted in the same cycle as a response handshake; minimum spacing is 2 cycles per operation.
REQ-016 ALU semantics are computed on 33-bit zero-extended operands; result = low 32 bits, carry = bit 32, zero = (result == 0):
- 1 add; 2 sub (carry = borrow); 3 shl; 4 shr; 5 sar (logical, since the operand is zero-extended; carry 0);
- 6 and; 7 or; 8 xor; 9 not (carry = 1);
- all other opcodes -> result 0, carry 0, zero 1.
REQ-017 Shift amounts SHALL use all 32 bits of b; an amount >= 33 yields result 0 and carry 0.
REQ-018 rsp<i>_ready asserted while rsp<i>_valid is 0 SHALL be ignored.
REQ-019 req<i>_valid dropped before accept SHALL have no effect, and req_valid inputs SHALL be ignored in RESP.

Reset
REQ-020 While rst_n = 0, regardless of clk, the block SHALL immediately hold the following values:
- state = IDLE;
- all rsp_valid = 0;
- all rsp data, carry and zero = 0;
- op_count = 0;
- last_grant = 1.
REQ-021 Reset asserted while in RESP SHALL discard the pending result without a handshake and without an op_count increment.
REQ-022 The first accept after rst_n rises SHALL be possible on the first clock edge with rst_n = 1.

Verification
REQ-023 The bench SHALL cover req0 only, add a=0xFFFFFFFF b=1 -> rsp0_valid next cycle, data 0, carry 1, zero 1; op_count 1 after rsp0_ready.
REQ-024 The bench SHALL cover both valid with FIXED_PRIORITY=0, req0 sub 5-7 and req1 xor 0xF0F0 ^ 0x0FF0, held valid -> grant order 0,1,0,1; rsp0 0xFFFFFFFE carry 1; rsp1 0xFF00 carry 0.
REQ-025 The bench SHALL cover FIXED_PRIORITY=1 with both valid held for 4 operations -> req1_ready never 1 and all 4 results go to requester 0.
REQ-026 The bench SHALL cover backpressure: rsp1_ready low for 5 cycles -> rsp1_valid and data held constant, both req_ready 0, op_count unchanged; handshake in cycle 6 -> IDLE.
REQ-027 The bench SHALL cover edge opcodes and reset mid-operation:
- shl a=0x80000001 b=1 -> data 0x00000002, carry 1;
- opcode 0xF -> data 0, carry 0, zero 1;
- rst_n low during RESP -> rsp_valid drops immediately and op_count = 0.
REQ-028 The bench SHALL cover op_count preset to 0xFFFF by running 65535 operations, then one more handshake -> op_count = 0x0000.
